// File: rtl/aud_ctrl_pkg.sv
// Shared types for the audio record/playback sequencer: FSM state codes,
// command-pulse bundle and clip region address helper.
package aud_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_t;

  typedef struct packed {
    logic rec_start;
    logic rec_pause;
    logic rec_stop;
    logic play_start;
    logic play_pause;
    logic play_stop;
  } cmd_t;

  // Base word address of a clip region: the clip index occupies the top address bits.
  function automatic logic [31:0] region_base(input logic [31:0] clip, input int unsigned shift);
    return clip << shift;
  endfunction

endpackage

// File: rtl/aud_clip_table.sv
// Per-clip register file holding {valid, last recorded address}.
// Registered write port, combinational read port, synchronous clear.
module aud_clip_table
  import aud_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned N_CLIPS = 4,
  parameter int unsigned CLIP_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [CLIP_W-1:0] i_wr_idx,
  input  logic [ADDR_W-1:0] i_wr_end,
  input  logic              i_wr_valid,
  input  logic [CLIP_W-1:0] i_rd_idx,
  output logic [ADDR_W-1:0] o_rd_end,
  output logic              o_rd_valid
);

  logic [ADDR_W:0] mem [N_CLIPS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(N_CLIPS); i++) mem[i] <= '0;
    end else if (i_wr_en) begin
      mem[i_wr_idx] <= {i_wr_valid, i_wr_end};
    end
  end

  assign o_rd_end   = mem[i_rd_idx][ADDR_W-1:0];
  assign o_rd_valid = mem[i_rd_idx][ADDR_W];

endmodule

// File: rtl/aud_clip_ctrl.sv
// Record/playback sequencer for the WM8731 audio path: clip regions, command pulses,
// I2C init hold and SRAM direction. Macro AUD_CLIP_CTRL_LOOP_EN enables seamless loop playback.
module aud_clip_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 20,
  parameter  int unsigned N_CLIPS   = 4,
  parameter  int unsigned INIT_HOLD = 2048,
  localparam int unsigned CLIP_W    = $clog2(N_CLIPS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [CLIP_W-1:0] i_clip_sel,
  input  logic              i_init_fin,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_play_fin,
  output logic              o_init_start,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic              o_play_en,
  output logic [ADDR_W-1:0] o_clip_base,
  output logic [ADDR_W-1:0] o_clip_end,
  output logic              o_sram_wr,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam int unsigned SHIFT      = ADDR_W - CLIP_W;
  localparam int unsigned INIT_CNT_W = (INIT_HOLD > 1) ? $clog2(INIT_HOLD) : 1;
  localparam logic [ADDR_W-1:0] REGION_LAST = {{CLIP_W{1'b0}}, {SHIFT{1'b1}}};

  state_t                state;
  cmd_t                  cmd_q;
  logic [CLIP_W-1:0]     clip_q;
  logic [INIT_CNT_W-1:0] init_cnt;

  logic [CLIP_W-1:0] rd_idx_c;
  logic [ADDR_W-1:0] rd_end_c;
  logic              rd_valid_c;
  logic [ADDR_W-1:0] base_sel_c;
  logic              full_c;
  logic              rec_done_c;
  logic              wr_valid_c;

  // In IDLE the table is looked up on the selector so a play decision sees the target clip.
  always_comb begin
    rd_idx_c   = (state == ST_IDLE) ? i_clip_sel : clip_q;
    base_sel_c = ADDR_W'(region_base(32'(i_clip_sel), SHIFT));
    full_c     = (i_rec_addr == (o_clip_base + REGION_LAST));
    rec_done_c = ((state == ST_RECD) && (i_key_stop || full_c)) ||
                 ((state == ST_RECD_PAUSE) && i_key_stop);
    wr_valid_c = (i_rec_addr != o_clip_base);
  end

  aud_clip_table #(
    .ADDR_W (ADDR_W),
    .N_CLIPS(N_CLIPS),
    .CLIP_W (CLIP_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (rec_done_c),
    .i_wr_idx  (clip_q),
    .i_wr_end  (i_rec_addr),
    .i_wr_valid(wr_valid_c),
    .i_rd_idx  (rd_idx_c),
    .o_rd_end  (rd_end_c),
    .o_rd_valid(rd_valid_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_INIT;
      cmd_q        <= '0;
      clip_q       <= '0;
      init_cnt     <= '0;
      o_init_start <= 1'b1;
      o_play_en    <= 1'b0;
      o_sram_wr    <= 1'b0;
      o_err        <= 1'b0;
      o_clip_base  <= '0;
      o_clip_end   <= '0;
    end else begin
      cmd_q <= '0;
      o_err <= 1'b0;

      if (init_cnt == INIT_CNT_W'(INIT_HOLD - 1)) o_init_start <= 1'b0;
      else init_cnt <= init_cnt + INIT_CNT_W'(1);

      case (state)
        ST_INIT: begin
          if (i_init_fin) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (i_key_stop) begin
            state <= ST_IDLE;
          end else if (i_key_rec) begin
            clip_q          <= i_clip_sel;
            o_clip_base     <= base_sel_c;
            o_clip_end      <= rd_end_c;
            cmd_q.rec_start <= 1'b1;
            o_sram_wr       <= 1'b1;
            state           <= ST_RECD;
          end else if (i_key_play) begin
            if (rd_valid_c) begin
              clip_q           <= i_clip_sel;
              o_clip_base      <= base_sel_c;
              o_clip_end       <= rd_end_c;
              cmd_q.play_start <= 1'b1;
              o_play_en        <= 1'b1;
              state            <= ST_PLAY;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ST_RECD: begin
          if (rec_done_c) begin
            cmd_q.rec_stop <= 1'b1;
            o_clip_end     <= i_rec_addr;
            o_sram_wr      <= 1'b0;
            state          <= ST_IDLE;
          end else if (i_key_rec) begin
            cmd_q.rec_pause <= 1'b1;
            o_sram_wr       <= 1'b0;
            state           <= ST_RECD_PAUSE;
          end
        end
        ST_RECD_PAUSE: begin
          if (rec_done_c) begin
            cmd_q.rec_stop <= 1'b1;
            o_clip_end     <= i_rec_addr;
            state          <= ST_IDLE;
          end else if (i_key_rec) begin
            cmd_q.rec_start <= 1'b1;
            o_sram_wr       <= 1'b1;
            state           <= ST_RECD;
          end
        end
        ST_PLAY: begin
          if (i_key_stop) begin
            cmd_q.play_stop <= 1'b1;
            o_play_en       <= 1'b0;
            state           <= ST_IDLE;
          end else if (i_play_fin) begin
`ifdef AUD_CLIP_CTRL_LOOP_EN
            cmd_q.play_start <= 1'b1;
`else
            cmd_q.play_stop <= 1'b1;
            o_play_en       <= 1'b0;
            state           <= ST_IDLE;
`endif
          end else if (i_key_play) begin
            cmd_q.play_pause <= 1'b1;
            o_play_en        <= 1'b0;
            state            <= ST_PLAY_PAUSE;
          end
        end
        ST_PLAY_PAUSE: begin
          if (i_key_stop) begin
            cmd_q.play_stop <= 1'b1;
            state           <= ST_IDLE;
          end else if (i_key_play) begin
            cmd_q.play_start <= 1'b1;
            o_play_en        <= 1'b1;
            state            <= ST_PLAY;
          end
        end
        default: begin
          o_play_en <= 1'b0;
          o_sram_wr <= 1'b0;
          state     <= ST_INIT;
        end
      endcase
    end
  end

  assign o_rec_start  = cmd_q.rec_start;
  assign o_rec_pause  = cmd_q.rec_pause;
  assign o_rec_stop   = cmd_q.rec_stop;
  assign o_play_start = cmd_q.play_start;
  assign o_play_pause = cmd_q.play_pause;
  assign o_play_stop  = cmd_q.play_stop;
  assign o_state      = state;

endmodule

// File: tb/tb_aud_clip_ctrl.sv
// Scoreboard bench for aud_clip_ctrl: per-cycle expectations are queued with the
// stimulus and popped when the registered outputs settle after the edge.
module tb_aud_clip_ctrl;

  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned N_CLIPS = 4;
  localparam int unsigned CLIP_W  = 2;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_RS   = 6'b100000;
  localparam logic [5:0] C_RP   = 6'b010000;
  localparam logic [5:0] C_RT   = 6'b001000;
  localparam logic [5:0] C_PS   = 6'b000100;
  localparam logic [5:0] C_PP   = 6'b000010;
  localparam logic [5:0] C_PT   = 6'b000001;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_REC  = 3'b100;
  localparam logic [2:0] K_PLAY = 3'b010;
  localparam logic [2:0] K_STOP = 3'b001;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_rec, key_play, key_stop;
  logic [CLIP_W-1:0] clip_sel;
  logic              init_fin;
  logic [ADDR_W-1:0] rec_addr;
  logic              play_fin;
  logic              init_start;
  logic              rec_start, rec_pause, rec_stop;
  logic              play_start, play_pause, play_stop;
  logic              play_en;
  logic [ADDR_W-1:0] clip_base, clip_end;
  logic              sram_wr, err;
  logic [2:0]        state;

  aud_clip_ctrl #(.ADDR_W(ADDR_W), .N_CLIPS(N_CLIPS), .INIT_HOLD(2048)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_rec   (key_rec),
    .i_key_play  (key_play),
    .i_key_stop  (key_stop),
    .i_clip_sel  (clip_sel),
    .i_init_fin  (init_fin),
    .i_rec_addr  (rec_addr),
    .i_play_fin  (play_fin),
    .o_init_start(init_start),
    .o_rec_start (rec_start),
    .o_rec_pause (rec_pause),
    .o_rec_stop  (rec_stop),
    .o_play_start(play_start),
    .o_play_pause(play_pause),
    .o_play_stop (play_stop),
    .o_play_en   (play_en),
    .o_clip_base (clip_base),
    .o_clip_end  (clip_end),
    .o_sram_wr   (sram_wr),
    .o_err       (err),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] cmd;
    logic       err;
    logic       play_en;
    logic       sram_wr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive keys for one cycle, queue the expected outputs, then compare after the edge.
  task automatic step(input logic [2:0] keys, input logic fin, input logic [2:0] st,
                      input logic [5:0] cmd, input logic e_err, input logic e_pen,
                      input logic e_swr);
    exp_t e;
    {key_rec, key_play, key_stop} = keys;
    play_fin = fin;
    exp_q.push_back('{st: st, cmd: cmd, err: e_err, play_en: e_pen, sram_wr: e_swr});
    tick();
    {key_rec, key_play, key_stop} = K_NONE;
    play_fin = 1'b0;
    e = exp_q.pop_front();
    check_eq("state",   32'(state), 32'(e.st));
    check_eq("cmd",     32'({rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}),
             32'(e.cmd));
    check_eq("err",     32'(err), 32'(e.err));
    check_eq("play_en", 32'(play_en), 32'(e.play_en));
    check_eq("sram_wr", 32'(sram_wr), 32'(e.sram_wr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {key_rec, key_play, key_stop} = K_NONE;
    clip_sel = '0;
    init_fin = 1'b0;
    rec_addr = '0;
    play_fin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    check_eq("rst_init_start", 32'(init_start), 32'd1);
    check_eq("rst_state",      32'(state), 32'd0);
    check_eq("rst_cmd", 32'({rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop}), 32'd0);
    check_eq("rst_flags",      32'({play_en, sram_wr, err}), 32'd0);
    check_eq("rst_clip_base",  32'(clip_base), 32'd0);
    check_eq("rst_clip_end",   32'(clip_end), 32'd0);

    // Keys ignored during INIT.
    step(K_REC,  1'b0, 3'd0, C_NONE, 1'b0, 1'b0, 1'b0);
    step(K_PLAY, 1'b0, 3'd0, C_NONE, 1'b0, 1'b0, 1'b0);

    while (cyc < 2047) tick();
    check_eq("init_start_c2047", 32'(init_start), 32'd1);
    tick();
    check_eq("init_start_c2048", 32'(init_start), 32'd0);
    while (cyc < 3000) tick();
    check_eq("state_c3000", 32'(state), 32'd0);
    init_fin = 1'b1;
    step(K_NONE, 1'b0, 3'd1, C_NONE, 1'b0, 1'b0, 1'b0);
    check_eq("init_start_idle", 32'(init_start), 32'd0);

    // Play on an empty clip.
    clip_sel = 2'd2;
    step(K_PLAY, 1'b0, 3'd1, C_NONE, 1'b1, 1'b0, 1'b0);
    step(K_NONE, 1'b0, 3'd1, C_NONE, 1'b0, 1'b0, 1'b0);

    // Record clip 1 with pause, selector change and cross-mode key.
    clip_sel = 2'd1;
    rec_addr = 20'h40000;
    step(K_REC,  1'b0, 3'd2, C_RS,   1'b0, 1'b0, 1'b1);
    clip_sel = 2'd3;
    rec_addr = 20'h40010;
    step(K_NONE, 1'b0, 3'd2, C_NONE, 1'b0, 1'b0, 1'b1);
    step(K_PLAY, 1'b0, 3'd2, C_NONE, 1'b0, 1'b0, 1'b1);
    step(K_REC,  1'b0, 3'd3, C_RP,   1'b0, 1'b0, 1'b0);
    step(K_REC,  1'b0, 3'd2, C_RS,   1'b0, 1'b0, 1'b1);
    rec_addr = 20'h41234;
    step(K_STOP, 1'b0, 3'd1, C_RT,   1'b0, 1'b0, 1'b0);
    step(K_PLAY, 1'b0, 3'd1, C_NONE, 1'b1, 1'b0, 1'b0);

    // Play clip 1: geometry, pause/resume, end of clip.
    clip_sel = 2'd1;
    step(K_PLAY, 1'b0, 3'd4, C_PS,   1'b0, 1'b1, 1'b0);
    check_eq("clip1_base", 32'(clip_base), 32'h40000);
    check_eq("clip1_end",  32'(clip_end),  32'h41234);
    step(K_REC,  1'b0, 3'd4, C_NONE, 1'b0, 1'b1, 1'b0);
    step(K_PLAY, 1'b0, 3'd5, C_PP,   1'b0, 1'b0, 1'b0);
    step(K_PLAY, 1'b0, 3'd4, C_PS,   1'b0, 1'b1, 1'b0);
`ifdef AUD_CLIP_CTRL_LOOP_EN
    step(K_NONE, 1'b1, 3'd4, C_PS,   1'b0, 1'b1, 1'b0);
    step(K_STOP | K_PLAY, 1'b0, 3'd1, C_PT, 1'b0, 1'b0, 1'b0);
`else
    step(K_NONE, 1'b1, 3'd1, C_PT,   1'b0, 1'b0, 1'b0);
`endif

    // Region full on clip 0; rec+play together resolves to record.
    clip_sel = 2'd0;
    rec_addr = 20'h3FFFC;
    step(K_REC | K_PLAY, 1'b0, 3'd2, C_RS, 1'b0, 1'b0, 1'b1);
    rec_addr = 20'h3FFFE;
    step(K_NONE, 1'b0, 3'd2, C_NONE, 1'b0, 1'b0, 1'b1);
    rec_addr = 20'h3FFFF;
    step(K_NONE, 1'b0, 3'd1, C_RT,   1'b0, 1'b0, 1'b0);
    step(K_PLAY, 1'b0, 3'd4, C_PS,   1'b0, 1'b1, 1'b0);
    check_eq("clip0_base", 32'(clip_base), 32'h00000);
    check_eq("clip0_end",  32'(clip_end),  32'h3FFFF);
    step(K_STOP | K_PLAY, 1'b0, 3'd1, C_PT, 1'b0, 1'b0, 1'b0);

    // Stop and rec together at the region base: stop only, clip stays empty.
    clip_sel = 2'd2;
    rec_addr = 20'h80000;
    step(K_REC,  1'b0, 3'd2, C_RS,   1'b0, 1'b0, 1'b1);
    step(K_STOP | K_REC, 1'b0, 3'd1, C_RT, 1'b0, 1'b0, 1'b0);
    step(K_PLAY, 1'b0, 3'd1, C_NONE, 1'b1, 1'b0, 1'b0);

    // Stop from record pause on clip 3.
    clip_sel = 2'd3;
    step(K_REC,  1'b0, 3'd2, C_RS,   1'b0, 1'b0, 1'b1);
    rec_addr = 20'hC0100;
    step(K_REC,  1'b0, 3'd3, C_RP,   1'b0, 1'b0, 1'b0);
    step(K_STOP, 1'b0, 3'd1, C_RT,   1'b0, 1'b0, 1'b0);
    step(K_PLAY, 1'b0, 3'd4, C_PS,   1'b0, 1'b1, 1'b0);
    check_eq("clip3_base", 32'(clip_base), 32'hC0000);
    check_eq("clip3_end",  32'(clip_end),  32'hC0100);
    step(K_PLAY, 1'b0, 3'd5, C_PP,   1'b0, 1'b0, 1'b0);
    step(K_STOP, 1'b0, 3'd1, C_PT,   1'b0, 1'b0, 1'b0);

    // Reset while playing: no stop pulse, table cleared.
    step(K_PLAY, 1'b0, 3'd4, C_PS,   1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step(K_NONE, 1'b0, 3'd0, C_NONE, 1'b0, 1'b0, 1'b0);
    check_eq("mid_rst_init_start", 32'(init_start), 32'd1);
    check_eq("mid_rst_clip_base",  32'(clip_base), 32'd0);
    check_eq("mid_rst_clip_end",   32'(clip_end), 32'd0);
    rst = 1'b0;
    step(K_NONE, 1'b0, 3'd1, C_NONE, 1'b0, 1'b0, 1'b0);
    clip_sel = 2'd1;
    step(K_PLAY, 1'b0, 3'd1, C_NONE, 1'b1, 1'b0, 1'b0);

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
